bm_output_arbiter: RTL



---
 rtl/bm_arb_pkg.sv | 19 +
 rtl/bm_rr_picker.sv | 32 +++
 rtl/bm_output_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bm_arb_pkg.sv
// Shared types and helpers for the BondMachine output arbiters.
// The grant FSM states, hold counter width and index-width helper live here.
package bm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2,
    ST_HOLD    = 2'd3
  } arb_state_t;

  localparam int HOLD_CNT_W = 16;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bm_rr_picker.sv
// Combinational round-robin picker: first set request bit strictly after ptr_i,
// wrapping around; found_o is low when no request is set.
module bm_rr_picker
  import bm_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             found_o
);

  int cand;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    // Scan from the farthest offset down so the nearest hit is the last write and wins.
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % N_REQ;
      if (req_i[IDX_W'(cand)]) begin
        sel_o   = IDX_W'(cand);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bm_output_arbiter.sv
// Round-robin sharing of one downstream output sink among N_REQ BondMachine
// output ports, with valid/received handshakes on both sides and a hold window.
module bm_output_arbiter
  import bm_arb_pkg::*;
#(
  parameter  int N_REQ       = 2,
  parameter  int DATA_W      = 1,
  parameter  int HOLD_CYCLES = 0,
  localparam int IDX_W       = idx_w(N_REQ)
) (
  input  logic                    clock_signal,
  input  logic                    reset_signal,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_received,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_received,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy
);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    valid_q, valid_d;
  logic [N_REQ-1:0]        recv_q, recv_d;
  logic [HOLD_CNT_W-1:0]   hold_q, hold_d;

  logic [IDX_W-1:0]        pick_sel;
  logic                    pick_found;
  logic [DATA_W-1:0]       sel_data;

  bm_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .sel_o   (pick_sel),
    .found_o (pick_found)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_sel == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    recv_d  = recv_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          data_d  = sel_data;
          grant_d = pick_sel;
          ptr_d   = pick_sel;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // The granted requester may drop valid here; the latched transfer still completes.
        if (out_received) begin
          valid_d          = 1'b0;
          recv_d           = '0;
          recv_d[grant_q]  = 1'b1;
          state_d          = ST_ACK;
        end
      end
      ST_ACK: begin
        recv_d = '0;
        if (HOLD_CYCLES > 0) begin
          hold_d  = HOLD_CNT_W'(HOLD_CYCLES);
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HOLD_CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clock_signal) begin
    if (!reset_signal) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      recv_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      recv_q  <= recv_d;
      hold_q  <= hold_d;
    end
  end

  assign req_received = recv_q;
  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign grant_idx    = grant_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
